// File: rtl/ic_bvashr_scmp_skolem_seq.sv
`default_nettype none
// ============================================================================
// ic_bvashr_scmp_skolem_seq : serial Skolem witness for (x >>a s) CMP t
// Revision: 1.0
// ============================================================================
module ic_bvashr_scmp_skolem_seq #(
   parameter int W  = 4,
   parameter int CW = $clog2(W + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   in_mode,
   input  logic [W-1:0] in_s,
   input  logic [W-1:0] in_t,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_sat,
   output logic [W-1:0] out_x,
   output logic [W-1:0] out_shr
);

   localparam logic [W-1:0]  MAXS   = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]  MINS   = {1'b1, {(W-1){1'b0}}};
   localparam logic [W:0]    W_WIDE = W[W:0];
   localparam logic [CW-1:0] W_CNT  = W[CW-1:0];

   localparam logic [1:0] M_SGE = 2'b00;
   localparam logic [1:0] M_SGT = 2'b01;
   localparam logic [1:0] M_SLE = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [1:0]    mode;
   logic [W-1:0]  t_q;
   logic [W-1:0]  r;
   logic [CW-1:0] cnt;

   logic [CW-1:0] k_in;
   logic [W-1:0]  base_in;
   logic [W-1:0]  base_q;
   logic          sat_w;

   // Shifting by W or more already yields pure sign fill, so saturate there.
   always_comb begin
      k_in    = ({1'b0, in_s} >= W_WIDE) ? W_CNT : in_s[CW-1:0];
      base_in = in_mode[1] ? MINS : MAXS;
      base_q  = mode[1] ? MINS : MAXS;
   end

   always_comb begin
      sat_w = 1'b0;
      case (mode)
         M_SGE:   sat_w = $signed(r) >= $signed(t_q);
         M_SGT:   sat_w = $signed(r) >  $signed(t_q);
         M_SLE:   sat_w = $signed(r) <= $signed(t_q);
         default: sat_w = $signed(r) <  $signed(t_q);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sat   <= 1'b0;
         out_x     <= '0;
         out_shr   <= '0;
         mode      <= 2'b00;
         t_q       <= '0;
         r         <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  mode     <= in_mode;
                  t_q      <= in_t;
                  r        <= base_in;
                  cnt      <= k_in;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (cnt != '0) begin
                  r   <= {r[W-1], r[W-1:1]};
                  cnt <= cnt - 1'b1;
               end else begin
                  out_shr   <= r;
                  out_sat   <= sat_w;
                  out_x     <= sat_w ? base_q : '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // in_ready rises with the handshake, so acceptance is one edge later.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ic_bvashr_scmp_skolem_seq.sv
`default_nettype none
// Testbench for ic_bvashr_scmp_skolem_seq (W = 4): directed vectors, mode/s/t sweep.
module tb_ic_bvashr_scmp_skolem_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] in_mode = 2'b00;
   logic [3:0] in_s = 4'h0;
   logic [3:0] in_t = 4'h0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_sat;
   logic [3:0] out_x;
   logic [3:0] out_shr;

   int total = 0;
   int bad   = 0;

   logic       exp_sat = 1'b0;
   logic [3:0] exp_x   = 4'h0;
   logic [3:0] exp_shr = 4'h0;

   ic_bvashr_scmp_skolem_seq #(.W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_s      (in_s),
      .in_t      (in_t),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sat   (out_sat),
      .out_x     (out_x),
      .out_shr   (out_shr)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] ashr(input logic [3:0] x, input logic [3:0] s);
      logic signed [3:0] xs;
      xs = x;
      return xs >>> s;
   endfunction

   function automatic logic pred(input logic [1:0] m, input logic [3:0] v, input logic [3:0] t);
      logic signed [3:0] a;
      logic signed [3:0] b;
      a = v;
      b = t;
      case (m)
         2'd0:    return a >= b;
         2'd1:    return a >  b;
         2'd2:    return a <= b;
         default: return a <  b;
      endcase
   endfunction

   // Brute force over every candidate x: the definition of satisfiability.
   function automatic logic exists_x(input logic [1:0] m, input logic [3:0] s, input logic [3:0] t);
      for (int x = 0; x < 16; x++)
         if (pred(m, ashr(4'(x), s), t)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic set_exp(input logic [1:0] m, input logic [3:0] s, input logic [3:0] t);
      logic [3:0] base;
      base    = m[1] ? 4'h8 : 4'h7;
      exp_sat = exists_x(m, s, t);
      exp_shr = ashr(base, s);
      exp_x   = exp_sat ? base : 4'h0;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         check("cmp_sat", 32'(out_sat), 32'(exp_sat));
         check("cmp_x", 32'(out_x), 32'(exp_x));
         check("cmp_shr", 32'(out_shr), 32'(exp_shr));
         check("cmp_in_ready_busy", 32'(in_ready), 32'd0);
      end
   end

   task automatic accept(input logic [1:0] m, input logic [3:0] s, input logic [3:0] t);
      logic acc;
      in_valid = 1'b1;
      in_mode  = m;
      in_s     = s;
      in_t     = t;
      acc      = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      in_mode  = 2'($urandom);
      in_s     = 4'($urandom);
      in_t     = 4'($urandom);
   endtask

   task automatic handshake(input int hold);
      repeat (hold) begin
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("hs_valid_drop", 32'(out_valid), 32'd0);
      check("hs_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic run(input logic [1:0] m, input logic [3:0] s, input logic [3:0] t,
                      input int hold, output int lat,
                      output logic sat, output logic [3:0] x, output logic [3:0] shr);
      int k;
      k = (s >= 4'd4) ? 4 : int'(s);
      set_exp(m, s, t);
      accept(m, s, t);
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
      end
      sat = out_sat;
      x   = out_x;
      shr = out_shr;
      check("latency", 32'(lat), 32'(k + 1));
      handshake(hold);
   endtask

   initial begin
      int lat;
      logic sat;
      logic [3:0] x;
      logic [3:0] shr;

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sat", 32'(out_sat), 32'd0);
      check("rst_out_x", 32'(out_x), 32'd0);
      check("rst_out_shr", 32'(out_shr), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors with literal expectations.
      run(2'd0, 4'd0, 4'h7, 0, lat, sat, x, shr);
      check("d1_sat", 32'(sat), 32'd1);
      check("d1_x", 32'(x), 32'h7);
      check("d1_shr", 32'(shr), 32'h7);
      check("d1_lat", 32'(lat), 32'd1);

      run(2'd0, 4'd2, 4'h2, 1, lat, sat, x, shr);
      check("d2_sat", 32'(sat), 32'd0);
      check("d2_x", 32'(x), 32'h0);
      check("d2_shr", 32'(shr), 32'h1);
      check("d2_lat", 32'(lat), 32'd3);

      run(2'd3, 4'd15, 4'hF, 0, lat, sat, x, shr);
      check("d3_sat", 32'(sat), 32'd0);
      check("d3_x", 32'(x), 32'h0);
      check("d3_shr", 32'(shr), 32'hF);
      check("d3_lat", 32'(lat), 32'd5);

      run(2'd2, 4'd1, 4'hC, 0, lat, sat, x, shr);
      check("d4_sat", 32'(sat), 32'd1);
      check("d4_x", 32'(x), 32'h8);
      check("d4_shr", 32'(shr), 32'hC);

      run(2'd1, 4'd3, 4'hF, 2, lat, sat, x, shr);
      check("d5_sat", 32'(sat), 32'd1);
      check("d5_x", 32'(x), 32'h7);
      check("d5_shr", 32'(shr), 32'h0);
      check("d5_lat", 32'(lat), 32'd4);

      // Backpressure with a pending request: SGT s=3 t=F gives sat=1, x=7, shr=0.
      set_exp(2'd1, 4'd3, 4'hF);
      accept(2'd1, 4'd3, 4'hF);
      for (int i = 0; i < 30 && !out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_mode  = 2'd0;
      in_s     = 4'd0;
      in_t     = 4'h7;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_shr", 32'(out_shr), 32'h0);
         check("bp_x", 32'(out_x), 32'h7);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_hs_valid", 32'(out_valid), 32'd0);
      check("bp_not_accepted", 32'(in_ready), 32'd1);
      set_exp(2'd0, 4'd0, 4'h7);
      @(posedge clk);
      #1;
      check("bp_accepted", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("bp_next_valid", 32'(out_valid), 32'd1);
      check("bp_next_shr", 32'(out_shr), 32'h7);
      check("bp_next_sat", 32'(out_sat), 32'd1);
      handshake(0);

      // Reset one shift edge into RUN aborts the request.
      set_exp(2'd0, 4'd3, 4'h0);
      accept(2'd0, 4'd3, 4'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_out_sat", 32'(out_sat), 32'd0);
      check("abort_out_x", 32'(out_x), 32'd0);
      check("abort_out_shr", 32'(out_shr), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run(2'd0, 4'd3, 4'h0, 0, lat, sat, x, shr);
      check("post_rst_sat", 32'(sat), 32'd1);
      check("post_rst_x", 32'(x), 32'h7);
      check("post_rst_shr", 32'(shr), 32'h0);

      // Full sweep against the existential reference.
      for (int m = 0; m < 4; m++)
         for (int s = 0; s < 16; s++)
            for (int t = 0; t < 16; t++) begin
               run(2'(m), 4'(s), 4'(t), 0, lat, sat, x, shr);
               check("sweep_sat", 32'(sat), 32'(exists_x(2'(m), 4'(s), 4'(t))));
               if (sat)
                  check("sweep_witness", 32'(pred(2'(m), ashr(x, 4'(s)), 4'(t))), 32'd1);
               else
                  check("sweep_x_zero", 32'(x), 32'd0);
            end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ic_bvashr_scmp_skolem_seq.md
Name: ic_bvashr_scmp_skolem_seq

Overview:
- Sequential, parametrised Skolem-witness engine for signed-compare invertibility conditions on arithmetic shift right, with the unknown x in operand position 0: find x such that (x >>a s) CMP t.
- CMP is selectable at runtime among SGE, SGT, SLE and SLT.
- Generalises the fixed-width, single-predicate combinational Skolem functions to width W.
- Applies the shift serially, one bit per cycle. Returns the satisfiability flag, the witness x and the shifted value over a valid/ready handshake for the solver-harness pipeline.

Parameters:
- W, 4, operand width of s, t and x (W >= 2).
- CW, $clog2(W+1), width of the internal shift counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  engine can accept a request.
- in_mode  input  2  predicate select: 00 SGE, 01 SGT, 10 SLE, 11 SLT.
- in_s  input  W  shift amount, unsigned.
- in_t  input  W  comparison target, two's complement.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_sat  output  1  1 = an x exists (the invertibility condition holds).
- out_x  output  W  witness x; 0 when out_sat = 0.
- out_shr  output  W  value of (base >>a s) used for the decision.

Behaviour:
- Reset (asynchronous assert, synchronous deassert on clk):
  - state = IDLE; in_ready = 1.
  - out_valid = 0, out_sat = 0, out_x = 0, out_shr = 0.
  - Internal registers cleared.
- Reset asserted mid-operation aborts the request. No output is produced for it.
- Witness base per mode:
  - SGE/SGT: MAXS = 0 followed by W-1 ones.
  - SLE/SLT: MINS = 1 followed by W-1 zeros.
  - These are the only witness candidates. MAXS >>a s is the largest and MINS >>a s the smallest reachable value for a given s.
- Effective shift k = min(in_s, W), unsigned. in_s >= W saturates: MAXS gives 0, MINS gives all ones.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch mode and t, r <= base, cnt <= k, go to RUN.
- RUN:
  - in_ready = 0.
  - If cnt != 0: r <= {r[W-1], r[W-1:1]}, cnt <= cnt - 1.
  - If cnt == 0: evaluate and register the outputs below, then go to DONE.
    - out_shr <= r.
    - out_sat <= (r >=s t) for SGE, (r >s t) for SGT, (r <=s t) for SLE, (r <s t) for SLT.
    - out_x <= base if sat, else 0.
    - out_valid <= 1.
- DONE:
  - out_valid = 1; outputs held stable.
  - On out_ready: out_valid <= 0, go to IDLE.
  - The next request can be accepted no earlier than the cycle after the output handshake (no overlap, single outstanding request).
- Latency: out_valid is high after exactly k+1 rising edges following the accepting edge.
- Signed compares use two's complement over the full W bits. No overflow is possible since there is no arithmetic.
- Inputs are sampled only on the accepting edge. Changes on in_s, in_t or in_mode afterwards have no effect.
- in_valid while busy is ignored and not queued. The producer holds it until in_ready.
- Edge cases:
  - s = 0: no shift, RUN lasts one cycle.
  - s = W-1: full sign spread.
  - s = all ones: saturates to W.

Test Plan (W = 4, MAXS = 0111, MINS = 1000):
- SGE, s=0, t=0111 -> out_sat=1, out_x=0111, out_shr=0111, out_valid 1 edge after accept.
- SGE, s=2, t=0010 -> out_shr=0001, out_sat=0, out_x=0000, out_valid 3 edges after accept.
- SLT, s=15, t=1111 -> shift saturates at 4, out_shr=1111, out_sat=0, out_x=0000, latency 5 edges.
- SLE, s=1, t=1100 -> out_shr=1100, out_sat=1, out_x=1000; SGT, s=3, t=1111 -> out_shr=0000, out_sat=1, out_x=0111.
- Backpressure: out_ready low 3 cycles after out_valid -> out_* stable, in_ready=0, a pending in_valid is not accepted. It is accepted on the edge after the out_ready handshake.
- Reset mid-RUN: SGE, s=3, drop rst_n after 1 shift edge -> immediately in_ready=1, out_valid=0, all outputs 0. A fresh request after release completes correctly.
- Exhaustive sweep: all mode/s/t for W=4 against the reference predicate "exists x in [0,15] with (x >>a s) CMP t". out_sat must match, and when out_sat=1, out_x must satisfy the predicate.
